iob_reset_sequencer: RTL and testbench

// - Parametrised successor to the board-level reset pulse generator.
// - Drives N_CH staged, active-high reset outputs from one system clock,

---
 rtl/iob_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_iob_reset_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_reset_sequencer.sv
// Staged reset sequencer: holds N_CH active-high resets, then releases them in index
// order once each channel's readiness input has been stable, with a watchdog per channel.
module iob_reset_sequencer #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 16,
    parameter int START        = 5,
    parameter int DURATION     = 10,
    parameter int STEP         = 4,
    parameter int TIMEOUT      = 1000,
    parameter int LOSS_RESTART = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cke_i,
    input  logic                      start_i,
    input  logic [N_CH-1:0]           ready_i,
    output logic [N_CH-1:0]           rst_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fault_o,
    output logic [$clog2(N_CH):0]     ch_o
);
    localparam int CH_W = $clog2(N_CH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START - 1);
    localparam logic [CNT_W-1:0] DUR_LAST   = CNT_W'(DURATION - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_HOLD,
        S_REL,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wd;
    logic [CH_W-1:0]  ch;
    logic [N_CH-1:0]  rst_q;
    logic             busy_q, done_q, fault_q;

    logic             ready_cur;
    logic [N_CH-1:0]  ch_sel;
    logic             restart;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Decode the active channel without indexing by ch, which reaches N_CH in DONE.
    always_comb begin
        ready_cur = 1'b0;
        ch_sel    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == CH_W'(k)) begin
                ready_cur = ready_i[k];
                ch_sel[k] = 1'b1;
            end
        end
    end

    assign restart = rst_i
                   | (cke_i & start_i)
                   | (cke_i & (state == S_DONE) & (LOSS_RESTART != 0) & ~(&ready_i));

    always_ff @(posedge clk_i) begin
        if (restart) begin
            state   <= S_WAIT;
            cnt     <= '0;
            wd      <= '0;
            ch      <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else if (cke_i) begin
            case (state)
                S_WAIT: begin
                    if (cnt == START_LAST) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_HOLD: begin
                    if (cnt == DUR_LAST) begin
                        state <= S_REL;
                        cnt   <= '0;
                        wd    <= '0;
                        ch    <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_REL: begin
                    // A release on the watchdog's last cycle still counts as a release.
                    if (ready_cur && cnt == STEP_LAST) begin
                        rst_q <= rst_q & ~ch_sel;
                        cnt   <= '0;
                        wd    <= '0;
                        ch    <= ch + CH_W'(1);
                        if (ch == CH_W'(N_CH - 1)) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else if (wd == TO_LAST) begin
                        state   <= S_FAULT;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        wd  <= sat_inc(wd);
                        cnt <= ready_cur ? sat_inc(cnt) : '0;
                    end
                end
                S_DONE:  ;
                S_FAULT: ;
                default: begin
                    state  <= S_WAIT;
                    cnt    <= '0;
                    rst_q  <= '1;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign rst_o   = rst_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign fault_o = fault_q;
    assign ch_o    = ch;
endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Directed bench for iob_reset_sequencer: nominal vector table plus hand-built corner sequences.
module tb_iob_reset_sequencer;
    logic       clk;
    logic       rst_i, cke_i, start_i;
    logic [2:0] ready_i;
    logic [2:0] rst_o, rst_o_nl;
    logic       busy_o, done_o, fault_o;
    logic       busy_nl, done_nl, fault_nl;
    logic [2:0] ch_o, ch_nl;

    int nchk = 0;
    int nerr = 0;
    int edge_n = 0;

    iob_reset_sequencer #(
        .N_CH(3), .CNT_W(16), .START(5), .DURATION(10), .STEP(4), .TIMEOUT(100), .LOSS_RESTART(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i), .start_i(start_i), .ready_i(ready_i),
        .rst_o(rst_o), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .ch_o(ch_o)
    );

    iob_reset_sequencer #(
        .N_CH(3), .CNT_W(16), .START(5), .DURATION(10), .STEP(4), .TIMEOUT(100), .LOSS_RESTART(0)
    ) dut_nl (
        .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i), .start_i(start_i), .ready_i(ready_i),
        .rst_o(rst_o_nl), .busy_o(busy_nl), .done_o(done_nl), .fault_o(fault_nl), .ch_o(ch_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [2:0] rst;
        logic       busy;
        logic       done;
        logic       fault;
        logic [2:0] ch;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic go(input int e);
        if (e > edge_n) tick(e - edge_n);
    endtask

    task automatic do_reset(input logic [2:0] rdy);
        rst_i   = 1'b1;
        cke_i   = 1'b1;
        start_i = 1'b0;
        ready_i = rdy;
        tick(2);
        rst_i  = 1'b0;
        edge_n = 0;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] r, input logic b, input logic d,
                           input logic f, input logic [2:0] c);
        chk({tag, ".rst"},   32'(rst_o),   32'(r));
        chk({tag, ".busy"},  32'(busy_o),  32'(b));
        chk({tag, ".done"},  32'(done_o),  32'(d));
        chk({tag, ".fault"}, 32'(fault_o), 32'(f));
        chk({tag, ".ch"},    32'(ch_o),    32'(c));
    endtask

    initial begin
        tbl[0] = '{1,  3'b111, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{15, 3'b111, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{18, 3'b111, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{19, 3'b110, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[4] = '{22, 3'b110, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[5] = '{23, 3'b100, 1'b1, 1'b0, 1'b0, 3'd2};
        tbl[6] = '{26, 3'b100, 1'b1, 1'b0, 1'b0, 3'd2};
        tbl[7] = '{27, 3'b000, 1'b0, 1'b1, 1'b0, 3'd3};
        tbl[8] = '{30, 3'b000, 1'b0, 1'b1, 1'b0, 3'd3};

        rst_i = 1'b1; cke_i = 1'b1; start_i = 1'b0; ready_i = 3'b111;

        // Reset state and nominal release timing
        do_reset(3'b111);
        chk_all("reset", 3'b111, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 9; i++) begin
            go(tbl[i].e);
            chk_all($sformatf("nom%0d", i), tbl[i].rst, tbl[i].busy, tbl[i].done, tbl[i].fault, tbl[i].ch);
            chk($sformatf("nom%0d.nl_rst", i), 32'(rst_o_nl), 32'(tbl[i].rst));
        end

        // Slow ready on channel 1: visible from edge 70, release on edge 73
        do_reset(3'b101);
        go(19);
        chk("slow.rel0", 32'(rst_o), 32'(3'b110));
        go(69);
        ready_i = 3'b111;
        go(72);
        chk("slow.pre", 32'(rst_o), 32'(3'b110));
        go(73);
        chk("slow.rel1", 32'(rst_o), 32'(3'b100));
        chk("slow.fault", 32'(fault_o), 32'd0);
        go(77);
        chk_all("slow.done", 3'b000, 1'b0, 1'b1, 1'b0, 3'd3);

        // Glitch filter: high 2, low 1, then needs 4 fresh cycles -> release on edge 26
        do_reset(3'b101);
        go(19);
        ready_i = 3'b111;
        go(21);
        ready_i = 3'b101;
        go(22);
        ready_i = 3'b111;
        go(25);
        chk("glitch.pre", 32'(rst_o), 32'(3'b110));
        go(26);
        chk("glitch.rel1", 32'(rst_o), 32'(3'b100));

        // Watchdog on channel 2 (entered at edge 23), then start_i recovery
        do_reset(3'b011);
        go(122);
        chk_all("wd.pre", 3'b100, 1'b1, 1'b0, 1'b0, 3'd2);
        go(123);
        chk_all("wd.fault", 3'b100, 1'b0, 1'b0, 1'b1, 3'd2);
        go(130);
        chk("wd.sticky", 32'(fault_o), 32'd1);
        start_i = 1'b1;
        go(131);
        start_i = 1'b0;
        ready_i = 3'b111;
        chk_all("wd.start", 3'b111, 1'b1, 1'b0, 1'b0, 3'd0);
        go(149);
        chk("wd.rerun.pre", 32'(rst_o), 32'(3'b111));
        go(150);
        chk("wd.rerun.rel0", 32'(rst_o), 32'(3'b110));
        go(158);
        chk_all("wd.rerun.done", 3'b000, 1'b0, 1'b1, 1'b0, 3'd3);

        // Loss restart in DONE: only the LOSS_RESTART=1 instance re-sequences
        do_reset(3'b111);
        go(30);
        ready_i = 3'b110;
        go(31);
        ready_i = 3'b111;
        chk_all("loss.restart", 3'b111, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("loss.nl_rst", 32'(rst_o_nl), 32'(3'b000));
        chk("loss.nl_done", 32'(done_nl), 32'd1);
        go(49);
        chk("loss.pre", 32'(rst_o), 32'(3'b111));
        go(50);
        chk("loss.rel0", 32'(rst_o), 32'(3'b110));
        go(58);
        chk("loss.done", 32'(done_o), 32'd1);
        chk("loss.nl_rst2", 32'(rst_o_nl), 32'(3'b000));

        // Freeze 7 edges during HOLD: releases shift to 26/30/34
        do_reset(3'b111);
        go(7);
        cke_i = 1'b0;
        go(10);
        chk("frz.mid.rst", 32'(rst_o), 32'(3'b111));
        chk("frz.mid.busy", 32'(busy_o), 32'd1);
        go(14);
        cke_i = 1'b1;
        go(25);
        chk("frz.pre", 32'(rst_o), 32'(3'b111));
        go(26);
        chk("frz.rel0", 32'(rst_o), 32'(3'b110));
        go(30);
        chk("frz.rel1", 32'(rst_o), 32'(3'b100));
        go(33);
        chk("frz.pre2", 32'(rst_o), 32'(3'b100));
        go(34);
        chk_all("frz.done", 3'b000, 1'b0, 1'b1, 1'b0, 3'd3);

        // rst_i pulse during REL aborts and auto-restarts
        do_reset(3'b111);
        go(21);
        chk("abort.before", 32'(rst_o), 32'(3'b110));
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        chk_all("abort.reset", 3'b111, 1'b1, 1'b0, 1'b0, 3'd0);
        edge_n = 0;
        go(18);
        chk("abort.pre", 32'(rst_o), 32'(3'b111));
        go(19);
        chk("abort.rel0", 32'(rst_o), 32'(3'b110));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
